// File: rtl/rv32i_pkg.sv
// RV32I encodings shared by the decode stage and the ALU: opcodes, ALU op codes,
// immediate formats and the decoded-instruction record.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU op = {2'b00, funct7[5], funct3}
  localparam logic [5:0] ALU_ADD  = 6'h00;
  localparam logic [5:0] ALU_SUB  = 6'h08;
  localparam logic [5:0] ALU_SLL  = 6'h01;
  localparam logic [5:0] ALU_SLT  = 6'h02;
  localparam logic [5:0] ALU_SLTU = 6'h03;
  localparam logic [5:0] ALU_XOR  = 6'h04;
  localparam logic [5:0] ALU_SRL  = 6'h05;
  localparam logic [5:0] ALU_SRA  = 6'h0D;
  localparam logic [5:0] ALU_OR   = 6'h06;
  localparam logic [5:0] ALU_AND  = 6'h07;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [5:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       src_a_pc;
    logic       src_b_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] funct3;
    logic       branch;
    logic       jump;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for the RV32I formats; purely combinational.
// The opcode bits carry no immediate data, so only instr[31:7] is taken.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_type_e   imm_type_i,
  output logic [31:0] imm_o
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves imm_o unassigned and infers a latch.
    imm_o = '0;
    case (imm_type_i)
      IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm_o = {instr_i[31:12], 12'b0};
      IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Registered RV32I decode stage: combinational decode into a one-entry output
// register with a valid/ready handshake and a highest-priority flush.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit NOP_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_alu_op,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_src_a_pc,
  output logic            out_src_b_imm,
  output logic            out_reg_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_funct3,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_t            dec;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        we_raw;
  imm_type_e   imm_type;
  dec_t        dec;
  entry_t      entry_d, entry_q;
  logic        valid_d, valid_q;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  imm_gen u_imm_gen (
    .instr_i    (in_instr[31:7]),
    .imm_type_i (imm_type),
    .imm_o      (imm)
  );

  always_comb begin
    dec        = '0;
    dec.rs1    = in_instr[19:15];
    dec.rd     = in_instr[11:7];
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    imm_type   = IMM_NONE;
    we_raw     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.rs2     = in_instr[24:20];
        dec.alu_op  = {2'b00, funct7[5], funct3};
        we_raw      = 1'b1;
        dec.illegal = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        imm_type      = IMM_I;
        dec.src_b_imm = 1'b1;
        dec.alu_op    = {3'b000, funct3};
        we_raw        = 1'b1;
        // Shift amounts live in imm[4:0]; the upper imm bits act as funct7.
        if (funct3 == 3'b001) begin
          dec.illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
          else dec.illegal = (funct7 != 7'b0000000);
        end
      end
      OPC_LOAD: begin
        imm_type      = IMM_I;
        dec.src_b_imm = 1'b1;
        dec.mem_rd    = 1'b1;
        we_raw        = 1'b1;
        dec.illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        imm_type      = IMM_S;
        dec.rs2       = in_instr[24:20];
        dec.rd        = '0;
        dec.src_b_imm = 1'b1;
        dec.mem_wr    = 1'b1;
        dec.illegal   = (funct3[2] || funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        imm_type    = IMM_B;
        dec.rs2     = in_instr[24:20];
        dec.rd      = '0;
        dec.branch  = 1'b1;
        dec.alu_op  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        dec.illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LUI: begin
        imm_type      = IMM_U;
        dec.rs1       = '0;
        dec.src_b_imm = 1'b1;
        we_raw        = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type      = IMM_U;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        we_raw        = 1'b1;
      end
      OPC_JAL: begin
        imm_type      = IMM_J;
        dec.rs1       = '0;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.jump      = 1'b1;
        we_raw        = 1'b1;
      end
      OPC_JALR: begin
        imm_type      = IMM_I;
        dec.src_b_imm = 1'b1;
        dec.jump      = 1'b1;
        we_raw        = 1'b1;
        dec.illegal   = (funct3 != 3'b000);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_we = we_raw && (in_instr[11:7] != 5'd0);
    if (dec.illegal) begin
      dec.alu_op = ALU_ADD;
      if (NOP_ILLEGAL) begin
        dec.reg_we = 1'b0;
        dec.mem_rd = 1'b0;
        dec.mem_wr = 1'b0;
        dec.branch = 1'b0;
        dec.jump   = 1'b0;
      end
    end
  end

  assign in_ready = !valid_q || out_ready;

  // Flush wins over everything; the payload is left alone since out_valid=0 masks it.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      entry_d = '{pc: in_pc, imm: imm, dec: dec};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload register is reset too, so every out_* reads 0 during reset, not just out_valid.
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates together at the edge.
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = entry_q.pc;
  assign out_imm       = entry_q.imm;
  assign out_alu_op    = entry_q.dec.alu_op;
  assign out_rs1       = entry_q.dec.rs1;
  assign out_rs2       = entry_q.dec.rs2;
  assign out_rd        = entry_q.dec.rd;
  assign out_src_a_pc  = entry_q.dec.src_a_pc;
  assign out_src_b_imm = entry_q.dec.src_b_imm;
  assign out_reg_we    = entry_q.dec.reg_we;
  assign out_mem_rd    = entry_q.dec.mem_rd;
  assign out_mem_wr    = entry_q.dec.mem_wr;
  assign out_funct3    = entry_q.dec.funct3;
  assign out_branch    = entry_q.dec.branch;
  assign out_jump      = entry_q.dec.jump;
  assign out_illegal   = entry_q.dec.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vectors, hold/drain, back-to-back, flush and async reset.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_alu_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_src_a_pc;
  logic        out_src_b_imm;
  logic        out_reg_we;
  logic        out_mem_rd;
  logic        out_mem_wr;
  logic [2:0]  out_funct3;
  logic        out_branch;
  logic        out_jump;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  id_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_alu_op    (out_alu_op),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_src_a_pc  (out_src_a_pc),
    .out_src_b_imm (out_src_b_imm),
    .out_reg_we    (out_reg_we),
    .out_mem_rd    (out_mem_rd),
    .out_mem_wr    (out_mem_wr),
    .out_funct3    (out_funct3),
    .out_branch    (out_branch),
    .out_jump      (out_jump),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_pc", out_pc, 32'd0);
    check("rst_alu", 32'(out_alu_op), 32'd0);
    rst_n = 1'b1;
    tick();

    // sub x0,x1,x2: latency 1, reg_we suppressed for rd=0
    offer(32'h40208033, 32'h100);
    #1;
    check("sub_pre_valid", 32'(out_valid), 32'd0);
    tick();
    check("sub_valid", 32'(out_valid), 32'd1);
    check("sub_alu", 32'(out_alu_op), 32'h08);
    check("sub_rs1", 32'(out_rs1), 32'd1);
    check("sub_rs2", 32'(out_rs2), 32'd2);
    check("sub_we", 32'(out_reg_we), 32'd0);
    check("sub_ill", 32'(out_illegal), 32'd0);
    check("sub_pc", out_pc, 32'h100);

    // Back-to-back stream with out_ready=1: one new entry per cycle
    offer(32'h4030D093, 32'h104);  // srai x1,x1,3
    tick();
    check("srai_valid", 32'(out_valid), 32'd1);
    check("srai_pc", out_pc, 32'h104);
    check("srai_alu", 32'(out_alu_op), 32'h0D);
    check("srai_imm", out_imm, 32'h403);
    check("srai_bimm", 32'(out_src_b_imm), 32'd1);
    check("srai_we", 32'(out_reg_we), 32'd1);
    check("srai_ill", 32'(out_illegal), 32'd0);

    offer(32'h40309093, 32'h108);  // slli with funct7=0100000: illegal
    tick();
    check("slli7_ill", 32'(out_illegal), 32'd1);
    check("slli7_alu", 32'(out_alu_op), 32'h00);
    check("slli7_we", 32'(out_reg_we), 32'd0);

    offer(32'hFE000EE3, 32'h10C);  // beq x0,x0,-4
    tick();
    check("beq_alu", 32'(out_alu_op), 32'h08);
    check("beq_br", 32'(out_branch), 32'd1);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_f3", 32'(out_funct3), 32'd0);
    check("beq_we", 32'(out_reg_we), 32'd0);

    offer(32'hFF812283, 32'h110);  // lw x5,-8(x2)
    tick();
    check("lw_rd_en", 32'(out_mem_rd), 32'd1);
    check("lw_imm", out_imm, 32'hFFFF_FFF8);
    check("lw_rd", 32'(out_rd), 32'd5);
    check("lw_rs1", 32'(out_rs1), 32'd2);
    check("lw_f3", 32'(out_funct3), 32'd2);
    check("lw_we", 32'(out_reg_we), 32'd1);

    offer(32'h00322623, 32'h114);  // sw x3,12(x4)
    tick();
    check("sw_wr", 32'(out_mem_wr), 32'd1);
    check("sw_we", 32'(out_reg_we), 32'd0);
    check("sw_imm", out_imm, 32'h0000_000C);
    check("sw_rs2", 32'(out_rs2), 32'd3);
    check("sw_rs1", 32'(out_rs1), 32'd4);

    offer(32'h123453B7, 32'h118);  // lui x7,0x12345
    tick();
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_rs1", 32'(out_rs1), 32'd0);
    check("lui_bimm", 32'(out_src_b_imm), 32'd1);
    check("lui_apc", 32'(out_src_a_pc), 32'd0);

    offer(32'h00001117, 32'h11C);  // auipc x2,1
    tick();
    check("auipc_imm", out_imm, 32'h0000_1000);
    check("auipc_apc", 32'(out_src_a_pc), 32'd1);

    offer(32'hFF9FF0EF, 32'h120);  // jal x1,-8
    tick();
    check("jal_imm", out_imm, 32'hFFFF_FFF8);
    check("jal_jump", 32'(out_jump), 32'd1);
    check("jal_apc", 32'(out_src_a_pc), 32'd1);
    check("jal_rs1", 32'(out_rs1), 32'd0);
    check("jal_we", 32'(out_reg_we), 32'd1);

    offer(32'h000110E7, 32'h124);  // jalr with funct3=001: illegal
    tick();
    check("jalr_ill", 32'(out_illegal), 32'd1);
    check("jalr_jump", 32'(out_jump), 32'd0);
    check("jalr_we", 32'(out_reg_we), 32'd0);

    offer(32'h00000010, 32'h128);  // instr[1:0]=00
    tick();
    check("lowbits_ill", 32'(out_illegal), 32'd1);

    offer(32'h4020C033, 32'h12C);  // OP funct7=0100000 with funct3=100
    tick();
    check("opf7_ill", 32'(out_illegal), 32'd1);

    offer(32'h4020D1B3, 32'h130);  // sra x3,x1,x2
    tick();
    check("sra_alu", 32'(out_alu_op), 32'h0D);
    check("sra_rd", 32'(out_rd), 32'd3);
    check("sra_ill", 32'(out_illegal), 32'd0);

    // Hold: add x1,x2,x3 held for 3 cycles while addi x2,x0,5 waits
    offer(32'h003100B3, 32'h200);
    tick();
    out_ready = 1'b0;
    offer(32'h00500113, 32'h204);
    #1;
    check("hold_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, 32'h200);
      check("hold_rs2", 32'(out_rs2), 32'd3);
      check("hold_imm", out_imm, 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 32'(in_ready), 32'd1);
    tick();
    check("next_pc", out_pc, 32'h204);
    check("next_imm", out_imm, 32'd5);
    check("next_bimm", 32'(out_src_b_imm), 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Flush while holding, with a new entry offered
    offer(32'h003100B3, 32'h300);
    tick();
    out_ready = 1'b0;
    offer(32'h00500113, 32'h304);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    tick();
    check("flush_valid2", 32'(out_valid), 32'd0);

    // Flush on an empty stage drops an entry that would otherwise be accepted
    out_ready = 1'b1;
    offer(32'h00500113, 32'h308);
    flush = 1'b1;
    #1;
    check("flush_empty_ready", 32'(in_ready), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_drop_valid", 32'(out_valid), 32'd0);

    // Async reset mid-stream with an entry held
    offer(32'h4030D093, 32'h400);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_pc", out_pc, 32'd0);
    check("arst_imm", out_imm, 32'd0);
    check("arst_alu", 32'(out_alu_op), 32'd0);
    check("arst_we", 32'(out_reg_we), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
